// File: rtl/game_dialog_pkg.sv
// Shared types for the dialog sequencer: FSM state encoding and key bit positions.
package game_dialog_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TYPE,
      HOLD,
      DONE
   } state_t;

   localparam int KEY_ADV  = 0;
   localparam int KEY_SKIP = 1;

endpackage

// File: rtl/game_dialog_sequencer_key_edge_sync.sv
// One-bit button conditioner: 2-flop synchronizer followed by a rising-edge pulse.
// A button already held when reset releases never yields a pulse until it has been seen low.
module key_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic press
);

   logic sync_p0, sync_p1, prev_p2;
   logic vld_p0, vld_p1;
   logic armed;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         prev_p2 <= 1'b0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         armed   <= 1'b0;
      end else begin
         sync_p0 <= key_raw;
         // stage p0 -> p1: second synchronizer flop
         sync_p1 <= sync_p0;
         vld_p0  <= 1'b1;
         vld_p1  <= vld_p0;
         // stage p1 -> p2: edge history; arm only once a genuine low sample has arrived
         prev_p2 <= sync_p1;
         if (vld_p1 && !sync_p1)
            armed <= 1'b1;
      end
   end

   assign press = armed & sync_p1 & ~prev_p2;

endmodule

// File: rtl/game_dialog_sequencer.sv
// Typewriter-style dialog box sequencer: pages of text revealed one character per N frames.
// Optional feature: define GAME_DIALOG_SKIP_EN to let key[1] finish the current page instantly.
module game_dialog_sequencer
   import game_dialog_pkg::*;
#(
   parameter int NUM_PAGES       = 4,
   parameter int CHARS_PER_PAGE  = 64,
   parameter int FRAMES_PER_CHAR = 2,
   localparam int PAGE_W         = $clog2(NUM_PAGES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        key,
   input  logic              vsync,
   output logic              dialog_on,
   output logic [PAGE_W-1:0] page,
   output logic [6:0]        reveal_cnt,
   output logic              busy,
   output logic              door
);

   localparam logic [6:0]        CHARS      = 7'(CHARS_PER_PAGE);
   localparam logic [3:0]        FRAME_LAST = 4'(FRAMES_PER_CHAR - 1);
   localparam logic [PAGE_W-1:0] PAGE_LAST  = PAGE_W'(NUM_PAGES - 1);

   state_t            state, state_nxt;
   logic [PAGE_W-1:0] page_nxt;
   logic [6:0]        reveal_nxt;
   logic [3:0]        frame_cnt, frame_nxt;
   logic              vsync_p0, tick_p1;
   logic              adv_press, skip_press;
   logic              unused_keys;

   assign unused_keys = ^key;

   key_edge_sync u_adv (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key[KEY_ADV]),
      .press   (adv_press)
   );

`ifdef GAME_DIALOG_SKIP_EN
   key_edge_sync u_skip (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key[KEY_SKIP]),
      .press   (skip_press)
   );
`else
   assign skip_press = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      page_nxt   = page;
      reveal_nxt = reveal_cnt;
      frame_nxt  = frame_cnt;
      case (state)
         IDLE: if (adv_press) begin
            state_nxt  = TYPE;
            page_nxt   = '0;
            reveal_nxt = '0;
            frame_nxt  = '0;
         end
         TYPE: begin
            // advance presses are deliberately not looked at here
            if (skip_press) begin
               reveal_nxt = CHARS;
               frame_nxt  = '0;
               state_nxt  = HOLD;
            end else if (reveal_cnt >= CHARS) begin
               state_nxt = HOLD;
            end else if (tick_p1) begin
               if (frame_cnt == FRAME_LAST) begin
                  frame_nxt  = '0;
                  reveal_nxt = reveal_cnt + 7'd1;
                  if (reveal_nxt == CHARS)
                     state_nxt = HOLD;
               end else begin
                  frame_nxt = frame_cnt + 4'd1;
               end
            end
         end
         HOLD: if (adv_press) begin
            if (page == PAGE_LAST) begin
               state_nxt = DONE;
            end else begin
               state_nxt  = TYPE;
               page_nxt   = page + PAGE_W'(1);
               reveal_nxt = '0;
               frame_nxt  = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         page       <= '0;
         reveal_cnt <= '0;
         frame_cnt  <= '0;
         vsync_p0   <= 1'b0;
         tick_p1    <= 1'b0;
         busy       <= 1'b0;
         door       <= 1'b0;
         dialog_on  <= 1'b0;
      end else begin
         // stage p0 -> p1: registered frame tick
         vsync_p0   <= vsync;
         tick_p1    <= vsync & ~vsync_p0;
         state      <= state_nxt;
         page       <= page_nxt;
         reveal_cnt <= reveal_nxt;
         frame_cnt  <= frame_nxt;
         busy       <= (state_nxt == TYPE);
         dialog_on  <= (state_nxt == TYPE) || (state_nxt == HOLD);
         door       <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_game_dialog_sequencer.sv
// Table-driven bench for game_dialog_sequencer with a queue of expected output snapshots.
module tb_game_dialog_sequencer;

   typedef enum int {OP_RESET, OP_ADV, OP_SKIP, OP_TICK, OP_RST_ASSERT, OP_RST_RELEASE_HELD} op_t;

   typedef struct {
      op_t op;
      int  arg;
      int  dialog_on;
      int  page;
      int  reveal;
      int  busy;
      int  door;
      bit  chk_pr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] key = 4'd0;
   logic       vsync = 1'b0;
   logic       dialog_on, busy, door;
   logic [1:0] page;
   logic [6:0] reveal_cnt;

   vec_t vecs[48];
   vec_t sb_q[$];
   int   nvec = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   game_dialog_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .vsync      (vsync),
      .dialog_on  (dialog_on),
      .page       (page),
      .reveal_cnt (reveal_cnt),
      .busy       (busy),
      .door       (door)
   );

   task automatic add(op_t op, int arg, int d, int p, int r, int b, int dr, bit chk_pr);
      vecs[nvec] = '{op, arg, d, p, r, b, dr, chk_pr};
      nvec++;
   endtask

   task automatic check(string name, int act, int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic press(int bitn);
      @(negedge clk);
      key[bitn] = 1'b1;
      repeat (5) @(negedge clk);
      key[bitn] = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vsync = 1'b1;
         @(negedge clk);
         @(negedge clk);
         vsync = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic apply(vec_t v);
      case (v.op)
         OP_RESET: begin
            @(negedge clk);
            rst = 1'b0; key = 4'd0; vsync = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (4) @(negedge clk);
         end
         OP_ADV:  press(0);
         OP_SKIP: press(1);
         OP_TICK: ticks(v.arg);
         OP_RST_ASSERT: begin
            @(negedge clk);
            #2 rst = 1'b0;
            #1;
         end
         OP_RST_RELEASE_HELD: begin
            rst = 1'b0;
            @(negedge clk);
            key[0] = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            repeat (8) @(negedge clk);
            key[0] = 1'b0;
            repeat (5) @(negedge clk);
         end
         default: ;
      endcase
   endtask

   initial begin
      int lat;
      vec_t exp_v;

      //   op                   arg  dlg pg  rev busy door chk_pr
      add(OP_RESET,             0,   0,  0,  0,  0,  0,   1);
      add(OP_ADV,               0,   1,  0,  0,  1,  0,   1);
      add(OP_TICK,              20,  1,  0,  10, 1,  0,   1);
      add(OP_ADV,               0,   1,  0,  10, 1,  0,   1);
      add(OP_TICK,              2,   1,  0,  11, 1,  0,   1);
      add(OP_TICK,              106, 1,  0,  64, 0,  0,   1);
      add(OP_TICK,              1,   1,  0,  64, 0,  0,   1);
      add(OP_ADV,               0,   1,  1,  0,  1,  0,   1);
      add(OP_TICK,              128, 1,  1,  64, 0,  0,   1);
      add(OP_ADV,               0,   1,  2,  0,  1,  0,   1);
      add(OP_TICK,              10,  1,  2,  5,  1,  0,   1);
`ifdef GAME_DIALOG_SKIP_EN
      add(OP_SKIP,              0,   1,  2,  64, 0,  0,   1);
      add(OP_TICK,              2,   1,  2,  64, 0,  0,   1);
`else
      add(OP_SKIP,              0,   1,  2,  5,  1,  0,   1);
      add(OP_TICK,              2,   1,  2,  6,  1,  0,   1);
`endif
      add(OP_RST_ASSERT,        0,   0,  0,  0,  0,  0,   1);
      add(OP_RST_RELEASE_HELD,  0,   0,  0,  0,  0,  0,   1);
      add(OP_ADV,               0,   1,  0,  0,  1,  0,   1);
      add(OP_TICK,              128, 1,  0,  64, 0,  0,   1);
      add(OP_ADV,               0,   1,  1,  0,  1,  0,   1);
      add(OP_TICK,              128, 1,  1,  64, 0,  0,   1);
      add(OP_ADV,               0,   1,  2,  0,  1,  0,   1);
      add(OP_TICK,              128, 1,  2,  64, 0,  0,   1);
      add(OP_ADV,               0,   1,  3,  0,  1,  0,   1);
      add(OP_TICK,              128, 1,  3,  64, 0,  0,   1);
      add(OP_ADV,               0,   0,  0,  0,  0,  1,   0);
      add(OP_ADV,               0,   0,  0,  0,  0,  1,   0);
      add(OP_SKIP,              0,   0,  0,  0,  0,  1,   0);
      add(OP_TICK,              3,   0,  0,  0,  0,  1,   0);

      for (int i = 0; i < nvec; i++) begin
         sb_q.push_back(vecs[i]);
         apply(vecs[i]);
         exp_v = sb_q.pop_front();
         check($sformatf("row%0d.dialog_on", i), int'(dialog_on), exp_v.dialog_on);
         check($sformatf("row%0d.busy", i), int'(busy), exp_v.busy);
         check($sformatf("row%0d.door", i), int'(door), exp_v.door);
         if (exp_v.chk_pr) begin
            check($sformatf("row%0d.page", i), int'(page), exp_v.page);
            check($sformatf("row%0d.reveal_cnt", i), int'(reveal_cnt), exp_v.reveal);
         end
      end

      // Advance-press latency from raw key edge to visible dialog box
      apply('{OP_RESET, 0, 0, 0, 0, 0, 0, 1'b0});
      @(negedge clk);
      key[0] = 1'b1;
      lat = 0;
      while (!dialog_on && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      total_cnt++;
      if (dialog_on && lat <= 4) pass_cnt++;
      else $display("FAIL adv_latency: %0d cycles with dialog_on=%0b, expected dialog_on=1 within 4 cycles", lat, dialog_on);
      check("adv_latency.busy", int'(busy), 1);
      check("adv_latency.page", int'(page), 0);
      key[0] = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/game_dialog_sequencer.md
GAME_DIALOG_SEQUENCER -- requirements
Module: game_dialog_sequencer

Interface
REQ-001 SHALL have parameter NUM_PAGES, default 4, number of dialog pages (2..16).
REQ-002 SHALL have parameter CHARS_PER_PAGE, default 64, characters revealed per page (1..127).
REQ-003 SHALL have parameter FRAMES_PER_CHAR, default 2, vsync frames between successive character reveals (1..15).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key  input  4  raw asynchronous buttons; key[0] advance, key[1] skip.
REQ-007 SHALL have port vsync  input  1  frame sync level from the vga_if timing chain; its rising edge is the frame tick.
REQ-008 SHALL have port dialog_on  output  1  dialog box visible.
REQ-009 SHALL have port page  output  $clog2(NUM_PAGES)  current page index, selecting the text ROM window.
REQ-010 SHALL have port reveal_cnt  output  7  number of characters of the current page the renderer may draw.
REQ-011 SHALL have port busy  output  1  typewriter reveal in progress.
REQ-012 SHALL have port door  output  1  dialog finished; door open.

Function
REQ-013 SHALL pass each key bit through a 2-flop synchronizer and a rising-edge detector; only one-cycle press pulses act.
REQ-014 SHALL detect vsync rising edge as a one-cycle frame tick, registered (1-cycle latency).
REQ-015 SHALL implement FSM states IDLE, TYPE, HOLD, DONE.
REQ-016 IDLE: dialog_on=0; advance press -> TYPE with page=0, reveal_cnt=0, frame counter=0.
REQ-017 TYPE: busy=1; each frame tick increments the frame counter; when it reaches FRAMES_PER_CHAR-1 it clears and reveal_cnt increments.
REQ-018 TYPE: when reveal_cnt reaches CHARS_PER_PAGE, next cycle -> HOLD; reveal_cnt SHALL never exceed CHARS_PER_PAGE.
REQ-019 TYPE: advance press SHALL be ignored (no page change, no buffering).
REQ-020 HOLD: busy=0; advance press with page<NUM_PAGES-1 -> page+1, reveal_cnt=0, -> TYPE.
REQ-021 HOLD: advance press with page=NUM_PAGES-1 -> DONE.
REQ-022 DONE: door=1, dialog_on=0, terminal until reset; all keys ignored.
REQ-023 Frame tick and advance press in the same cycle in TYPE: tick processed, press dropped.
REQ-024 Outputs SHALL be registered; state change visible on outputs the cycle after the triggering edge.
REQ-025 dialog_on SHALL be 1 in TYPE and HOLD only.

Reset
REQ-026 rst low SHALL immediately force IDLE, page=0, reveal_cnt=0, busy=0, door=0, dialog_on=0, frame counter=0, synchronizers and edge detectors cleared, regardless of state.
REQ-027 After rst release, a key held high through reset SHALL NOT produce a press pulse.

Configuration
REQ-028 With GAME_DIALOG_SKIP_EN defined, skip press in TYPE SHALL set reveal_cnt=CHARS_PER_PAGE and enter HOLD next cycle; skip has no effect in other states.
REQ-029 Without GAME_DIALOG_SKIP_EN, key[1] SHALL be fully ignored and its synchronizer omitted.

Structure
REQ-030 Package game_dialog_pkg SHALL hold the state enum (IDLE, TYPE, HOLD, DONE) and key bit-index constants KEY_ADV=0, KEY_SKIP=1.
REQ-031 Sub-module key_edge_sync (2-flop sync + rising-edge pulse, one bit, async active-low reset) SHALL be instantiated per used key bit.

Verification
REQ-032 Reset, advance pulse -> dialog_on=1, page=0, busy=1 within 4 cycles of key edge (sync + edge + register).
REQ-033 Defaults, 128 vsync edges in TYPE -> reveal_cnt=64, busy=0, state HOLD; 129th edge -> reveal_cnt stays 64.
REQ-034 Advance in TYPE at reveal_cnt=10 -> page stays 0, reveal_cnt continues 11 after next 2 frames.
REQ-035 Four full pages then advance in HOLD of page 3 -> door=1, dialog_on=0; further presses -> no change.
REQ-036 GAME_DIALOG_SKIP_EN, skip at reveal_cnt=5 -> reveal_cnt=64, busy=0 next cycle; without macro -> reveal continues.
REQ-037 rst asserted mid-TYPE on page 2 -> all outputs zero asynchronously; key[0] held across release -> remains IDLE.
